muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_iter.sv | 106 ++++++++++
 rtl/muldiv_ctrl.sv | 115 +++++++++++
 tb/tb_muldiv_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the operand width, the op encodings, the controller state
// encoding and the magnitude/negate helpers.
// Optional build macro used by this unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + (2*XLEN)'(1)) : v;
  endfunction

  // Magnitude of v; only negative when treated as signed.
  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v, input logic is_signed);
    return neg32(v, is_signed && v[XLEN-1]);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the main pipeline FSM and the mul/div unit.
//   master: start, op, src_a, src_b, hi_wr, lo_wr, wr_data -> unit
//   slave : busy, done, div_zero, hi, lo                    -> pipeline
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            hi_wr;
  logic            lo_wr;
  logic [XLEN-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_wr, lo_wr, wr_data,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath shared by multiply and divide.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture magnitudes and mode, clear counter
//   step         perform one shift-add or restoring-divide iteration
//   is_div       mode sampled on load
//   mag_a, mag_b operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   calc_done    the current step is the final one
//   result       multiply: 64-bit product; divide: {remainder, quotient}
// With MULDIV_EARLY_OUT_EN defined, multiplies finish once the remaining
// multiplier bits are all zero.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic              calc_done,
  output logic [2*XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sr_q, sr_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div_q, div_d;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic              last;

  always_comb begin
    acc_d  = acc_q;
    sr_d   = sr_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;

    // Multiply: add multiplicand into the upper half, then shift the whole
    // accumulator right so the next multiplier bit lines up at bit XLEN.
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (sr_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: shift {rem, dividend} left, try subtracting the divisor.
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    rem_ge  = rem_sh >= {1'b0, opnd_q};
    rem_new = rem_ge ? XLEN'(rem_sh - {1'b0, opnd_q}) : rem_sh[XLEN-1:0];

    if (load) begin
      cnt_d = '0;
      div_d = is_div;
      if (is_div) begin
        acc_d  = {{XLEN{1'b0}}, mag_a};
        opnd_d = mag_b;
        sr_d   = '0;
      end else begin
        acc_d  = '0;
        opnd_d = mag_a;
        sr_d   = mag_b;
      end
    end else if (step) begin
      cnt_d = cnt_q + CntW'(1);
      if (div_q) begin
        acc_d = {rem_new, acc_q[XLEN-2:0], rem_ge};
      end else begin
        acc_d = {add_sum, acc_q[XLEN-1:1]};
        sr_d  = sr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  assign last = (cnt_q == CntW'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_done = last || (!div_q && (sr_q[XLEN-1:1] == '0));
  // After n of XLEN steps the product sits (XLEN - n) places too high.
  assign result = div_q ? acc_q : (acc_q >> (CntW'(XLEN) - cnt_q));
`else
  assign calc_done = last;
  assign result    = acc_q;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS-style multiply/divide controller with architectural HI/LO.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  muldiv_if.slave: start/op/src_a/src_b launch an operation,
//        hi_wr/lo_wr/wr_data implement mthi/mtlo, busy/done/div_zero
//        report progress, hi/lo are the architectural registers.
// Build macro: MULDIV_EARLY_OUT_EN (early multiply termination).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_e state_q, state_d;

  logic            div_q, dz_q, neg_res_q, neg_rem_q;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

  logic              op_div, op_signed, b_zero, accept;
  logic              load, step, calc_done;
  logic [2*XLEN-1:0] result;

  assign op_div    = bus.op[1];
  assign op_signed = !bus.op[0];
  assign b_zero    = (bus.src_b == '0);
  assign accept    = (state_q == StIdle) && bus.start;

  muldiv_iter u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .is_div    (op_div),
    .mag_a     (abs32(bus.src_a, op_signed)),
    .mag_b     (abs32(bus.src_b, op_signed)),
    .calc_done (calc_done),
    .result    (result)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (op_div && b_zero) begin
            state_d = StFin;
          end else begin
            state_d = StCalc;
            load    = 1'b1;
          end
        end
      end
      StCalc: begin
        step = 1'b1;
        if (calc_done) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // mthi/mtlo land only while idle; a result lands on the edge leaving FIN,
  // overwriting any write made alongside the start.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == StIdle) begin
      if (bus.hi_wr) hi_d = bus.wr_data;
      if (bus.lo_wr) lo_d = bus.wr_data;
    end else if (state_q == StFin && !dz_q) begin
      if (div_q) begin
        hi_d = neg32(result[2*XLEN-1:XLEN], neg_rem_q);
        lo_d = neg32(result[XLEN-1:0], neg_res_q);
      end else begin
        {hi_d, lo_d} = neg64(result, neg_res_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (accept) begin
        div_q     <= op_div;
        dz_q      <= op_div && b_zero;
        neg_res_q <= op_signed && (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
        neg_rem_q <= op_signed && bus.src_a[XLEN-1];
      end
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StFin);
  assign bus.div_zero = (state_q == StFin) && dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
// Honours MULDIV_EARLY_OUT_EN for the expected multiply latency.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_if bus ();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the start edge to the done cycle for a multiply by |b|.
  function automatic int mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return 1 + n;
`else
    return 33 + 0 * int'(b[0]);
`endif
  endfunction

  task automatic mtx(input bit h, input bit l, input logic [31:0] d);
    bus.hi_wr   = h;
    bus.lo_wr   = l;
    bus.wr_data = d;
    tick();
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b0;
  endtask

  // Launch one op; optionally write HI with the start, or poke start+lo_wr
  // at cycle k+poke_at while busy. Then check latency, flags and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic dz,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int poke_at, input bit wr_start);
    int n;
    bit busy_ok;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    if (wr_start) begin
      bus.hi_wr   = 1'b1;
      bus.wr_data = 32'hcafe_0000;
    end
    tick();
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    bus.src_a = ~a;
    bus.src_b = ~b;
    bus.op    = ~o;
    if (wr_start) chk({tag, " hi written with start"}, 64'(bus.hi), 64'h cafe_0000);
    n       = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (n == poke_at) begin
        bus.start   = 1'b1;
        bus.lo_wr   = 1'b1;
        bus.wr_data = 32'h0bad_f00d;
      end
      tick();
      n++;
      bus.start = 1'b0;
      bus.lo_wr = 1'b0;
    end
    chk({tag, " done latency"}, 64'(n), 64'(lat));
    chk({tag, " busy before done"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy in fin"}, 64'(bus.busy), 64'd1);
    chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(dz));
    tick();
    chk({tag, " busy after fin"}, 64'(bus.busy), 64'd0);
    chk({tag, " done single pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.hi_wr   = 1'b0;
    bus.lo_wr   = 1'b0;
    bus.wr_data = '0;
    rst         = 1'b1;
    tick();
    tick();
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset div_zero", 64'(bus.div_zero), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;

    run_op("multu max", OpMultu, 32'hffff_ffff, 32'hffff_ffff, mul_lat(32'hffff_ffff), 1'b0,
           32'hffff_fffe, 32'h0000_0001, 0, 1'b0);
    run_op("mult -7x3", OpMult, 32'hffff_fff9, 32'd3, mul_lat(32'd3), 1'b0,
           32'hffff_ffff, 32'hffff_ffeb, 0, 1'b1);
    run_op("mult -3x-5", OpMult, 32'hffff_fffd, 32'hffff_fffb, mul_lat(32'd5), 1'b0,
           32'h0, 32'd15, 0, 1'b0);
    run_op("div -7/2", OpDiv, 32'hffff_fff9, 32'd2, 33, 1'b0,
           32'hffff_ffff, 32'hffff_fffd, 0, 1'b0);
    run_op("div 7/-2", OpDiv, 32'd7, 32'hffff_fffe, 33, 1'b0,
           32'd1, 32'hffff_fffd, 0, 1'b0);
    run_op("div min/-1", OpDiv, 32'h8000_0000, 32'hffff_ffff, 33, 1'b0,
           32'h0, 32'h8000_0000, 0, 1'b0);

    mtx(1'b1, 1'b0, 32'h1111_1111);
    chk("mthi hi", 64'(bus.hi), 64'h1111_1111);
    chk("mthi leaves lo", 64'(bus.lo), 64'h8000_0000);
    mtx(1'b0, 1'b1, 32'h1234_5678);
    mtx(1'b1, 1'b0, 32'h1234_5678);
    chk("preset hi", 64'(bus.hi), 64'h1234_5678);
    chk("preset lo", 64'(bus.lo), 64'h1234_5678);
    run_op("divu by zero", OpDivu, 32'd100, 32'd0, 1, 1'b1,
           32'h1234_5678, 32'h1234_5678, 0, 1'b0);

    mtx(1'b1, 1'b1, 32'haabb_ccdd);
    chk("mthi+mtlo hi", 64'(bus.hi), 64'haabb_ccdd);
    chk("mthi+mtlo lo", 64'(bus.lo), 64'haabb_ccdd);

    run_op("multu 2x3 poked", OpMultu, 32'd2, 32'd3, mul_lat(32'd3), 1'b0,
           32'h0, 32'd6, 5, 1'b0);

    mtx(1'b1, 1'b1, 32'h5555_aaaa);
    bus.start = 1'b1;
    bus.op    = OpDivu;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("abort busy before rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort hi", 64'(bus.hi), 64'd0);
    chk("abort lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    run_op("divu 100/7 after rst", OpDivu, 32'd100, 32'd7, 33, 1'b0,
           32'd2, 32'd14, 0, 1'b0);

    run_op("multu 9x5", OpMultu, 32'd9, 32'd5, mul_lat(32'd5), 1'b0,
           32'h0, 32'd45, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
